// File: rtl/ram_frame_loader_pkg.sv
// Shared definitions for the stream-to-RAM frame loader (default geometry, FSM encoding).
// Optional LIFO drain order is selected in the top with RAM_FRAME_LOADER_REVERSE_EN.
package ram_frame_loader_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_frame_loader_if.sv
// Valid/ready byte stream with a last marker; master drives payload, slave drives ready.
interface ram_frame_loader_if
    import ram_frame_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              valid;
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/ram_frame_loader_frame_ptr_counter.sv
// Frame pointer counter with clear, load, increment and decrement (priority in that order).
module frame_ptr_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + ONE;
        end else if (dec) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/ram_frame_loader.sv
// Store-and-forward controller for an external single-port RAM: fills one frame, then drains it.
// Define RAM_FRAME_LOADER_REVERSE_EN to drain the frame in LIFO order instead of FIFO order.
//
//   state | meaning
//   EMPTY | no frame stored, waiting for the first byte
//   FILL  | frame partially written, accepting bytes
//   DRAIN | frame closed, streaming it out of the RAM
module ram_frame_loader
    import ram_frame_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    ram_frame_loader_if.slave   in_stream,
    ram_frame_loader_if.master  out_stream,
    output logic [ADDR_W:0]     frame_len,
    output logic                frame_full,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_dout
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

    state_t          state;
    state_t          state_nxt;
    logic [ADDR_W:0] wr_cnt;
    logic [ADDR_W:0] rd_cnt;
    logic            draining;
    logic            wr_hs;
    logic            rd_hs;
    logic            at_cap;
    logic            closing;
    logic            last_beat;
    logic            frame_full_nxt;
    logic            wr_clr;
    logic            rd_clr;
    logic            rd_load;
    logic            rd_inc;
    logic            rd_dec;

    assign draining        = (state == DRAIN);
    assign in_stream.ready = !draining && !reset;
    assign wr_hs           = in_stream.valid && in_stream.ready;
    assign rd_hs           = out_stream.valid && out_stream.ready;

    // Write pointer and stored length are the same count while filling.
    assign frame_len = wr_cnt;
    assign at_cap    = (wr_cnt == LAST_IDX);
    assign closing   = wr_hs && (in_stream.last || at_cap);

    assign ram_we   = wr_hs;
    assign ram_din  = in_stream.data;
    assign ram_addr = draining ? rd_cnt[ADDR_W-1:0] : wr_cnt[ADDR_W-1:0];

    assign out_stream.valid = draining;
    assign out_stream.data  = ram_dout;
    assign out_stream.last  = draining && last_beat;

`ifdef RAM_FRAME_LOADER_REVERSE_EN
    // Read pointer preloads to the closing byte's address, then walks down to 0.
    assign last_beat = (rd_cnt == '0);
    assign rd_load   = closing;
    assign rd_inc    = 1'b0;
    assign rd_dec    = rd_hs;
`else
    assign last_beat = (rd_cnt == (wr_cnt - ONE));
    assign rd_load   = 1'b0;
    assign rd_inc    = rd_hs;
    assign rd_dec    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            frame_full <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_full <= frame_full_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        frame_full_nxt = 1'b0;
        wr_clr         = 1'b0;
        rd_clr         = 1'b0;
        case (state)
            EMPTY, FILL: begin
                if (closing) begin
                    state_nxt      = DRAIN;
                    frame_full_nxt = !in_stream.last;
                end else if (wr_hs) begin
                    state_nxt = FILL;
                end
            end
            DRAIN: begin
                if (rd_hs && last_beat) begin
                    state_nxt = EMPTY;
                    wr_clr    = 1'b1;
                    rd_clr    = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    frame_ptr_counter #(.W(ADDR_W + 1)) u_wr_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (wr_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (wr_hs),
        .dec      (1'b0),
        .count    (wr_cnt)
    );

    frame_ptr_counter #(.W(ADDR_W + 1)) u_rd_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (rd_clr),
        .load     (rd_load),
        .load_val (wr_cnt),
        .inc      (rd_inc),
        .dec      (rd_dec),
        .count    (rd_cnt)
    );

endmodule
